// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command issuer.
//   ALU_DATA_W : default operand/result width of the ALU
//   OP_*       : ALU opcode encodings
//   issuer_state_e : command issuer FSM states
package alu_pkg;

  localparam int ALU_DATA_W = 4;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_SUB     = 3'd1;
  localparam logic [2:0] OP_NOT     = 3'd2;
  localparam logic [2:0] OP_AND     = 3'd3;
  localparam logic [2:0] OP_OR      = 3'd4;
  localparam logic [2:0] OP_XOR     = 3'd5;
  localparam logic [2:0] OP_COMPARE = 3'd6;
  localparam logic [2:0] OP_EQUAL   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } issuer_state_e;

endpackage

// File: rtl/alu_cmd_issuer.sv
// Sequential front end for the combinational ALU.
// Accepts (op, A, B) commands over a valid/ready channel, drives registered
// operands into the ALU, captures its result/flags one cycle later and
// returns them over a valid/ready response channel. Also keeps an
// accumulator (last non-overflowed result) and a saturating overflow count.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op, cmd_a, cmd_b        command opcode and operands
//   cmd_acc                     use accumulator as operand A
//   acc_clr                     synchronous accumulator clear
//   alu_op, alu_a, alu_b        registered ALU inputs
//   alu_result/overflow/zero    ALU outputs
//   rsp_valid/rsp_ready         response handshake
//   rsp_result/overflow/zero    captured ALU outputs
//   acc                         accumulator
//   ovf_count                   saturating overflow counter
//   busy                        command in flight (EXEC or RESP)
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_acc,
  input  logic              acc_clr,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_overflow,
  output logic              rsp_zero,
  output logic [DATA_W-1:0] acc,
  output logic [CNT_W-1:0]  ovf_count,
  output logic              busy
);

  issuer_state_e r_state;
  issuer_state_e w_state_nxt;

  logic [2:0]        r_alu_op;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [DATA_W-1:0] r_rsp_result;
  logic              r_rsp_overflow;
  logic              r_rsp_zero;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_ovf_count;

  logic w_cmd_ready;
  logic w_accept;
  logic w_exec;

  // A response slot frees up in the same cycle it is consumed, so RESP can
  // take the next command directly and sustain one command per two cycles.
  assign w_cmd_ready = (r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready);
  assign w_accept    = cmd_valid && w_cmd_ready;
  assign w_exec      = (r_state == ST_EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = cmd_valid ? ST_EXEC : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand A samples the accumulator as it stands before any coincident
  // acc_clr takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_op <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
    end else if (w_accept) begin
      r_alu_op <= cmd_op;
      r_alu_a  <= cmd_acc ? r_acc : cmd_a;
      r_alu_b  <= cmd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b0;
      r_rsp_zero     <= 1'b0;
    end else if (w_exec) begin
      r_rsp_result   <= alu_result;
      r_rsp_overflow <= alu_overflow;
      r_rsp_zero     <= alu_zero;
    end
  end

  // Clear has priority over the EXEC update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (acc_clr) begin
      r_acc <= '0;
    end else if (w_exec && !alu_overflow) begin
      r_acc <= alu_result;
    end
  end

  // Saturates at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_count <= '0;
    end else if (w_exec && alu_overflow && (r_ovf_count != {CNT_W{1'b1}})) begin
      r_ovf_count <= r_ovf_count + CNT_W'(1);
    end
  end

  assign cmd_ready    = w_cmd_ready;
  assign alu_op       = r_alu_op;
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign rsp_valid    = (r_state == ST_RESP);
  assign rsp_result   = r_rsp_result;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_zero     = r_rsp_zero;
  assign acc          = r_acc;
  assign ovf_count    = r_ovf_count;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer. Two issuers (CNT_W=8 and CNT_W=2) share the same
// stimulus; each drives its own behavioural 4-bit signed ALU. Expected values
// come from a transaction-level model of the accumulator and overflow count.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic       cmd_acc = 1'b0;
  logic       acc_clr = 1'b0;
  logic       rsp_ready = 1'b0;

  logic       cmd_ready, rsp_valid, rsp_overflow, rsp_zero, busy;
  logic [2:0] alu_op;
  logic [3:0] alu_a, alu_b, alu_result, rsp_result, acc;
  logic       alu_overflow, alu_zero;
  logic [7:0] ovf_count;

  logic       cmd_ready2, rsp_valid2, rsp_overflow2, rsp_zero2, busy2;
  logic [2:0] alu_op2;
  logic [3:0] alu_a2, alu_b2, alu_result2, rsp_result2, acc2;
  logic       alu_overflow2, alu_zero2;
  logic [1:0] ovf_count2;

  int n_pass = 0;
  int n_total = 0;

  logic [3:0] macc = '0;
  int         mcnt = 0;

  always #5 clk = ~clk;

  // 4-bit signed ALU: returns {overflow, result}; overflow forces result 0.
  function automatic logic [4:0] alu_f(input logic [2:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    int sa, sb, s;
    logic [3:0] r;
    logic ovf;
    sa = $signed(a);
    sb = $signed(b);
    ovf = 1'b0;
    r = '0;
    case (op)
      OP_ADD:     begin s = sa + sb; ovf = (s > 7) || (s < -8); r = 4'(s); end
      OP_SUB:     begin s = sa - sb; ovf = (s > 7) || (s < -8); r = 4'(s); end
      OP_NOT:     r = ~a;
      OP_AND:     r = a & b;
      OP_OR:      r = a | b;
      OP_XOR:     r = a ^ b;
      OP_COMPARE: r = (sa < sb) ? 4'd1 : 4'd0;
      OP_EQUAL:   r = (a == b) ? 4'd1 : 4'd0;
      default:    r = '0;
    endcase
    if (ovf) r = '0;
    return {ovf, r};
  endfunction

  assign {alu_overflow, alu_result}   = alu_f(alu_op, alu_a, alu_b);
  assign alu_zero                     = (alu_result == 4'd0);
  assign {alu_overflow2, alu_result2} = alu_f(alu_op2, alu_a2, alu_b2);
  assign alu_zero2                    = (alu_result2 == 4'd0);

  alu_cmd_issuer #(.DATA_W(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc), .acc_clr(acc_clr),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .acc(acc), .ovf_count(ovf_count), .busy(busy)
  );

  alu_cmd_issuer #(.DATA_W(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc), .acc_clr(acc_clr),
    .alu_op(alu_op2), .alu_a(alu_a2), .alu_b(alu_b2),
    .alu_result(alu_result2), .alu_overflow(alu_overflow2), .alu_zero(alu_zero2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_result(rsp_result2),
    .rsp_overflow(rsp_overflow2), .rsp_zero(rsp_zero2),
    .acc(acc2), .ovf_count(ovf_count2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] cap(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic chk_counts();
    chk("ovf_count", ovf_count, cap(mcnt, 255));
    chk("ovf_count_sat2", ovf_count2, cap(mcnt, 3));
  endtask

  // One command from IDLE, optionally stalling the response for 'stall' cycles.
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic use_acc, input logic clr_acc, input logic clr_exec,
                       input int stall);
    logic [3:0] aeff;
    logic [4:0] r;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    chk("rsp_valid_idle", rsp_valid, 0);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = use_acc;
    acc_clr = clr_acc;
    @(posedge clk);
    aeff = use_acc ? macc : a;
    if (clr_acc) macc = '0;
    r = alu_f(op, aeff, b);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_a = 4'($urandom); cmd_b = 4'($urandom);
    acc_clr = clr_exec;
    chk("exec_busy", busy, 1);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_cmd_ready", cmd_ready, 0);
    chk("alu_op", alu_op, op);
    chk("alu_a", alu_a, aeff);
    chk("alu_b", alu_b, b);
    @(posedge clk);
    if (r[4]) mcnt++;
    if (clr_exec) macc = '0;
    else if (!r[4]) macc = r[3:0];
    @(negedge clk);
    acc_clr = 1'b0;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_result", rsp_result, r[3:0]);
    chk("rsp_overflow", rsp_overflow, r[4]);
    chk("rsp_zero", rsp_zero, (r[3:0] == 4'd0));
    chk("acc", acc, macc);
    chk_counts();
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_result", rsp_result, r[3:0]);
      chk("stall_rsp_overflow", rsp_overflow, r[4]);
      chk("stall_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("resp_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_rsp_hold", rsp_result, r[3:0]);
  endtask

  // n commands with cmd_valid and rsp_ready held high.
  task automatic b2b(input int n, input logic rnd);
    logic [3:0] aeff;
    logic [4:0] r;
    logic [4:0] prev;
    logic [2:0] op;
    logic [3:0] a, b;
    logic       ua;
    prev = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      op = rnd ? 3'($urandom) : OP_ADD;
      a  = rnd ? 4'($urandom) : 4'(i + 1);
      b  = rnd ? 4'($urandom) : 4'd1;
      ua = rnd ? 1'($urandom) : 1'b0;
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_rsp_valid", rsp_valid, 1);
        chk("b2b_rsp_result", rsp_result, prev[3:0]);
        chk("b2b_rsp_overflow", rsp_overflow, prev[4]);
      end
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = ua;
      #1;
      chk("b2b_cmd_ready", cmd_ready, 1);
      @(posedge clk);
      aeff = ua ? macc : a;
      r = alu_f(op, aeff, b);
      @(negedge clk);
      chk("b2b_exec_rsp_valid", rsp_valid, 0);
      chk("b2b_alu_a", alu_a, aeff);
      @(posedge clk);
      if (r[4]) mcnt++;
      else macc = r[3:0];
      prev = r;
    end
    @(negedge clk);
    chk("b2b_last_valid", rsp_valid, 1);
    chk("b2b_last_result", rsp_result, prev[3:0]);
    chk("b2b_acc", acc, macc);
    chk_counts();
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_idle_valid", rsp_valid, 0);
    chk("b2b_idle_busy", busy, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acc", acc, 0);
    chk("rst_alu_a", alu_a, 0);
    chk_counts();
    rst_n = 1'b1;

    // Directed plan
    issue(OP_ADD, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 0);
    chk("t1_acc", acc, 4'd7);
    issue(OP_ADD, 4'd7, 4'd1, 1'b0, 1'b0, 1'b0, 0);
    chk("t2_acc", acc, 4'd7);
    chk("t2_ovf", ovf_count, 8'd1);
    issue(OP_SUB, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 0);
    chk("t3_sub_acc", acc, 4'd5);
    issue(OP_COMPARE, 4'd0, 4'd6, 1'b1, 1'b0, 1'b0, 0);
    chk("t3_cmp_acc", acc, 4'd1);
    @(negedge clk);
    acc_clr = 1'b1;
    @(posedge clk);
    macc = '0;
    @(negedge clk);
    acc_clr = 1'b0;
    chk("t3_clr_acc", acc, 0);
    issue(OP_ADD, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 5);
    b2b(3, 1'b0);
    // Clear coincident with cmd_acc acceptance and with the EXEC update
    issue(OP_OR, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 0);
    issue(OP_XOR, 4'd5, 4'd3, 1'b0, 1'b0, 1'b1, 1);
    chk("clr_exec_acc", acc, 0);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      issue(3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            $urandom_range(0, 3));
    end
    b2b(6, 1'b1);

    // Reset during EXEC
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 4'd1; cmd_b = 4'd2; cmd_acc = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    macc = '0;
    mcnt = 0;
    chk("arst_alu_op", alu_op, 0);
    chk("arst_alu_a", alu_a, 0);
    chk("arst_alu_b", alu_b, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_result", rsp_result, 0);
    chk("arst_rsp_overflow", rsp_overflow, 0);
    chk("arst_rsp_zero", rsp_zero, 0);
    chk("arst_acc", acc, 0);
    chk("arst_busy", busy, 0);
    chk_counts();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", rsp_valid, 0);
      chk("post_rst_cmd_ready", cmd_ready, 1);
    end

    // Overflow counter saturation
    for (int i = 0; i < 5; i++) begin
      issue(OP_ADD, 4'd7, 4'd1, 1'b0, 1'b0, 1'b0, 0);
    end
    chk("sat_ovf8", ovf_count, 8'd5);
    chk("sat_ovf2", ovf_count2, 2'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
